// File: rtl/posit_encoder.sv
// Posit encoder: packs (scale, mantissa) into an N-bit posit, regime emitted serially.
// Define POSIT_ENC_RNE_EN for round-to-nearest-even; otherwise the body is truncated.
module posit_encoder #(
  parameter int N       = 32,
  parameter int ES      = 3,
  parameter int SCALE_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign_in,
  input  logic               zero_in,
  input  logic               nar_in,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [63:0]        mant_in,
  output logic [N-1:0]       posit_out,
  output logic               busy,
  output logic               done
);

  localparam int BW = ES + 62;
  localparam int CW = $clog2(N) + 1;
  localparam logic signed [SCALE_W-1:0] KLIM = SCALE_W'(N - 2);
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = N'(1);
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, SETUP, REGIME, ROUND, DONE
  } state_t;

  state_t state_q, state_d;

  logic                      sign_q, zero_q, nar_q;
  logic signed [SCALE_W-1:0] scale_q;
  logic [61:0]               frac_q;
  logic [BW-1:0]             b_q;
  logic [CW-1:0]             rlen_q, cnt_q;
  logic                      neg_q;

  logic signed [SCALE_W-1:0] k, kneg;
  logic                      clamp_hi, clamp_lo, special;
  logic [N-1:0]              spec_mag, spec_res;
  logic [CW-1:0]             rlen_d;
  logic                      last, ins;

  logic [N-2:0]              body, body_r;
  logic                      guard;
  logic [BW-N-1:0]           rest;
  logic [N-1:0]              mag, posit_d;

  logic                      unused_in;
  assign unused_in = ^mant_in[63:62];

  assign k        = scale_q >>> ES;
  assign kneg     = -k;
  assign clamp_hi = !k[SCALE_W-1] && (k >= KLIM);
  assign clamp_lo = k[SCALE_W-1] && (kneg >= KLIM);
  assign special  = nar_q | zero_q | clamp_hi | clamp_lo;
  assign spec_mag = clamp_hi ? MAXPOS : MINPOS;

  always_comb begin
    spec_res = sign_q ? -spec_mag : spec_mag;
    if (zero_q) spec_res = '0;
    if (nar_q)  spec_res = NAR;
  end

  assign rlen_d = k[SCALE_W-1] ? CW'(kneg) + CW'(1)
                               : CW'(k) + CW'(2);
  assign last   = (cnt_q == rlen_q - CW'(1));
  // terminator goes in first so it lands below the run
  assign ins    = (cnt_q == '0) ? neg_q : ~neg_q;

  assign body  = b_q[BW-1 -: N-1];
  assign guard = b_q[BW-N];
  assign rest  = b_q[BW-N-1:0];

`ifdef POSIT_ENC_RNE_EN
  logic sticky_q;
  logic st_all, rnd;
  assign st_all = sticky_q | (|rest);
  assign rnd    = guard & (st_all | body[0]) & ~(&body);
  assign body_r = body + {{(N-2){1'b0}}, rnd};
`else
  logic unused_low;
  assign unused_low = ^{guard, rest};
  assign body_r     = body;
`endif

  assign mag     = {1'b0, body_r};
  assign posit_d = sign_q ? -mag : mag;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = special ? DONE : REGIME;
      REGIME:  if (last) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      nar_q     <= 1'b0;
      scale_q   <= '0;
      frac_q    <= '0;
      b_q       <= '0;
      rlen_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      posit_out <= '0;
`ifdef POSIT_ENC_RNE_EN
      sticky_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          sign_q  <= sign_in;
          zero_q  <= zero_in;
          nar_q   <= nar_in;
          scale_q <= scale_in;
          frac_q  <= mant_in[61:0];
        end
        SETUP: begin
          b_q    <= {scale_q[ES-1:0], frac_q};
          rlen_q <= rlen_d;
          neg_q  <= k[SCALE_W-1];
          cnt_q  <= '0;
`ifdef POSIT_ENC_RNE_EN
          sticky_q <= 1'b0;
`endif
          if (special) posit_out <= spec_res;
        end
        REGIME: begin
          b_q   <= {ins, b_q[BW-1:1]};
          cnt_q <= cnt_q + CW'(1);
`ifdef POSIT_ENC_RNE_EN
          sticky_q <= sticky_q | b_q[0];
`endif
        end
        ROUND:   posit_out <= posit_d;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed bench for posit_encoder (N=32, ES=3).
// Expected values hand-derived; RNE-dependent cases follow POSIT_ENC_RNE_EN.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_in, zero_in, nar_in;
  logic [9:0]  scale_in;
  logic [63:0] mant_in;
  logic [31:0] posit_out;
  logic        busy, done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] M1 = 64'h4000_0000_0000_0000;

  posit_encoder #(.N(32), .ES(3), .SCALE_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign_in   (sign_in),
    .zero_in   (zero_in),
    .nar_in    (nar_in),
    .scale_in  (scale_in),
    .mant_in   (mant_in),
    .posit_out (posit_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag,
                     input logic s, input logic z, input logic na,
                     input logic [9:0] sc, input logic [63:0] m,
                     input logic [31:0] ex, input int lat);
    int n;
    @(negedge clk);
    sign_in  = s;
    zero_in  = z;
    nar_in   = na;
    scale_in = sc;
    mant_in  = m;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(lat));
    check({tag, ".posit"}, 64'(posit_out), 64'(ex));
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 64'({done, busy}), 64'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1 if (done) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask

  logic [31:0] e_tie1, e_tie2, e_max;
  int nw;

  initial begin
`ifdef POSIT_ENC_RNE_EN
    e_tie1 = 32'h4000_0001;
    e_tie2 = 32'h4000_0002;
    e_max  = 32'h7FFF_FFFF;
`else
    e_tie1 = 32'h4000_0000;
    e_tie2 = 32'h4000_0001;
    e_max  = 32'h7FFF_FFFE;
`endif
    reset    = 1'b1;
    start    = 1'b0;
    sign_in  = 1'b0;
    zero_in  = 1'b0;
    nar_in   = 1'b0;
    scale_in = '0;
    mant_in  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.posit", 64'(posit_out), 64'd0);
    check("rst.flags", 64'({busy, done}), 64'd0);

    run("t1", 0, 0, 0, 10'd0, M1, 32'h4000_0000, 5);
    run("t2", 1, 0, 0, 10'd8, M1, 32'hA000_0000, 6);
    run("t3", 0, 0, 0, 10'(-1), M1, 32'h3C00_0000, 5);
    run("t3n", 1, 0, 0, 10'(-8), M1, 32'hE000_0000, 5);
    run("hi", 0, 0, 0, 10'd300, M1, 32'h7FFF_FFFF, 2);
    run("hin", 1, 0, 0, 10'd300, M1, 32'h8000_0001, 2);
    run("lo", 0, 0, 0, 10'(-300), M1, 32'h0000_0001, 2);
    run("lon", 1, 0, 0, 10'(-300), M1, 32'hFFFF_FFFF, 2);
    run("nar", 0, 1, 1, 10'd0, M1, 32'h8000_0000, 2);
    run("zero", 1, 1, 0, 10'd0, M1, 32'h0000_0000, 2);
    run("k30", 0, 0, 0, 10'd240, M1, 32'h7FFF_FFFF, 2);
    run("km30", 0, 0, 0, 10'(-240), M1, 32'h0000_0001, 2);
    run("k29", 0, 0, 0, 10'd232, M1, 32'h7FFF_FFFE, 34);
    run("km29", 0, 0, 0, 10'(-232), M1, 32'h0000_0002, 33);
    run("tie0", 0, 0, 0, 10'd0, 64'h4000_0008_0000_0000,
        32'h4000_0000, 5);
    run("tie0s", 0, 0, 0, 10'd0, 64'h4000_0008_0000_0001,
        e_tie1, 5);
    run("tie1", 0, 0, 0, 10'd0, 64'h4000_0018_0000_0000,
        e_tie2, 5);
    run("k29e7", 0, 0, 0, 10'd239, M1, e_max, 34);

    // second start mid-encode must be dropped
    @(negedge clk);
    sign_in  = 1'b0;
    scale_in = 10'd0;
    mant_in  = M1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    sign_in  = 1'b1;
    scale_in = 10'd8;
    @(posedge clk);
    #1 start = 1'b0;
    nw = 0;
    while (!done && nw < 100) begin
      @(posedge clk);
      #1 nw++;
    end
    check("ign.done", 64'(done), 64'd1);
    check("ign.posit", 64'(posit_out), 64'h4000_0000);
    quiet("ign.noq", 12);

    // reset while in REGIME
    run("pre", 1, 0, 0, 10'd8, M1, 32'hA000_0000, 6);
    @(negedge clk);
    sign_in  = 1'b0;
    scale_in = 10'd8;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rmid.flags", 64'({busy, done}), 64'd0);
    check("rmid.posit", 64'(posit_out), 64'd0);
    quiet("rmid.noq", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
